// File: rtl/shift_port_arbiter_if.sv
// Handshake and serial-load bundle between two word requesters, the arbiter
// and the downstream serial-in shift register.
interface shift_port_arbiter_if #(
    parameter int WIDTH = 4
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_data;
    logic             req1_ready;
    logic             shift_en;
    logic             shift_bit;
    logic             busy;
    logic             grant_id;
    logic             done;
    logic             done_id;

    modport master (
        output req0_valid, req0_data,
        input  req0_ready,
        output req1_valid, req1_data,
        input  req1_ready,
        input  shift_en, shift_bit, busy, grant_id, done, done_id
    );

    modport slave (
        input  req0_valid, req0_data,
        output req0_ready,
        input  req1_valid, req1_data,
        output req1_ready,
        output shift_en, shift_bit, busy, grant_id, done, done_id
    );
endinterface

// File: rtl/shift_port_arbiter.sv
// Round-robin arbiter that loads one requester's word into a shared serial-in
// shift register, LSB first, then pulses done with the owner's id.
module shift_port_arbiter #(
    parameter int WIDTH = 4,
    parameter int GAP   = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    shift_port_arbiter_if.slave   arb_io
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [3:0]       GAP_INIT = 4'(GAP);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE,
        S_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       gap_q, gap_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             last_q, last_d;
    logic             grant_q, grant_d;
    logic             shift_en_q, shift_en_d;
    logic             shift_bit_q, shift_bit_d;
    logic             done_q, done_d;
    logic             done_id_q, done_id_d;
    logic             sel1, ready0, ready1;

    // A tie goes to whichever requester did not win last time.
    always_comb begin
        sel1   = arb_io.req1_valid && (!arb_io.req0_valid || !last_q);
        ready0 = (state_q == S_IDLE) && arb_io.req0_valid && !sel1;
        ready1 = (state_q == S_IDLE) && sel1;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        word_d    = word_q;
        last_d    = last_q;
        grant_d   = grant_q;
        done_id_d = done_id_q;
        unique case (state_q)
            S_IDLE: begin
                if (ready0) begin
                    word_d  = arb_io.req0_data;
                    grant_d = 1'b0;
                    last_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end else if (ready1) begin
                    word_d  = arb_io.req1_data;
                    grant_d = 1'b1;
                    last_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (GAP_INIT == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d   = GAP_INIT;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q <= 4'd1) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Serial outputs are registered from the next state so the bit for
        // counter value N is presented during the cycle the FSM sits at N.
        shift_en_d  = (state_d == S_SHIFT);
        shift_bit_d = shift_en_d & word_d[cnt_d];
        done_d      = (state_d == S_DONE);
        if (done_d) begin
            done_id_d = grant_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            gap_q       <= 4'd0;
            last_q      <= 1'b1;
            grant_q     <= 1'b0;
            shift_en_q  <= 1'b0;
            shift_bit_q <= 1'b0;
            done_q      <= 1'b0;
            done_id_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            last_q      <= last_d;
            grant_q     <= grant_d;
            shift_en_q  <= shift_en_d;
            shift_bit_q <= shift_bit_d;
            done_q      <= done_d;
            done_id_q   <= done_id_d;
        end
    end

    always_ff @(posedge clock) begin
        word_q <= word_d;
    end

    assign arb_io.req0_ready = ready0;
    assign arb_io.req1_ready = ready1;
    assign arb_io.shift_en   = shift_en_q;
    assign arb_io.shift_bit  = shift_bit_q;
    assign arb_io.busy       = (state_q != S_IDLE);
    assign arb_io.grant_id   = grant_q;
    assign arb_io.done       = done_q;
    assign arb_io.done_id    = done_id_q;
endmodule

// File: tb/tb_shift_port_arbiter.sv
// Directed bench: a GAP=1 arbiter for most scenarios and a GAP=0 arbiter for
// back-to-back throughput, each feeding a modelled serial-in shift register.
module tb_shift_port_arbiter;
    localparam int W = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    shift_port_arbiter_if #(.WIDTH(W)) a_if ();
    shift_port_arbiter_if #(.WIDTH(W)) b_if ();

    shift_port_arbiter #(.WIDTH(W), .GAP(1)) dut_gap1 (
        .clock  (clock),
        .reset  (reset),
        .arb_io (a_if.slave)
    );

    shift_port_arbiter #(.WIDTH(W), .GAP(0)) dut_gap0 (
        .clock  (clock),
        .reset  (reset),
        .arb_io (b_if.slave)
    );

    // Downstream register: new bit enters Q[W-1], oldest ends in Q[0].
    logic [W-1:0] q_a, q_b;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_a <= '0;
            q_b <= '0;
        end else begin
            if (a_if.shift_en) q_a <= {a_if.shift_bit, q_a[W-1:1]};
            if (b_if.shift_en) q_b <= {b_if.shift_bit, q_b[W-1:1]};
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        a_if.req0_valid = 1'b0; a_if.req1_valid = 1'b0;
        b_if.req0_valid = 1'b0; b_if.req1_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Follows one transfer on a_if starting just after the accept edge.
    task automatic observe(output logic [W-1:0] bits, output int first_en, output int nen,
                           output int done_cyc, output logic did, output logic [W-1:0] regv);
        bits = '0; first_en = -1; nen = 0; done_cyc = -1; did = 1'b0; regv = '0;
        for (int c = 1; c <= W + 4; c++) begin
            @(negedge clock); #1;
            if (a_if.shift_en) begin
                if (first_en < 0) first_en = c;
                if (nen < W) bits[nen] = a_if.shift_bit;
                nen++;
            end
            if (a_if.done) begin
                done_cyc = c; did = a_if.done_id; regv = q_a;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [7:0] outs;
        @(negedge clock); #1;
        outs = {a_if.shift_en, a_if.shift_bit, a_if.busy, a_if.grant_id,
                a_if.done, a_if.done_id, a_if.req0_ready, a_if.req1_ready};
        n_cmp++;
        if (outs !== 8'h00) begin n_err++; $display("FAIL reset_outputs: got %b, expected 00000000", outs); end
        n_cmp++;
        if (q_a !== 4'h0) begin n_err++; $display("FAIL reset_register: got %h, expected 0", q_a); end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_single();
        logic [W-1:0] bits, regv; int fe, nen, dc; logic did;
        do_reset();
        @(negedge clock);
        a_if.req0_valid = 1'b1; a_if.req0_data = 4'b1011;
        #1;
        n_cmp++;
        if ({a_if.req0_ready, a_if.req1_ready} !== 2'b10) begin
            n_err++; $display("FAIL single_ready: got %b, expected 10", {a_if.req0_ready, a_if.req1_ready});
        end
        @(posedge clock); #1;
        a_if.req0_valid = 1'b0;
        observe(bits, fe, nen, dc, did, regv);
        n_cmp++;
        if (bits !== 4'b1011) begin n_err++; $display("FAIL single_bits: got %b, expected 1011 (LSB first)", bits); end
        n_cmp++;
        if (fe !== 1 || nen !== 4) begin n_err++; $display("FAIL single_shift_en: first %0d count %0d, expected 1 and 4", fe, nen); end
        n_cmp++;
        if (dc !== 5) begin n_err++; $display("FAIL single_done_cycle: got %0d, expected 5", dc); end
        n_cmp++;
        if (did !== 1'b0) begin n_err++; $display("FAIL single_done_id: got %b, expected 0", did); end
        n_cmp++;
        if (regv !== 4'b1011) begin n_err++; $display("FAIL single_register: got %b, expected 1011", regv); end
        @(negedge clock); #1;
        n_cmp++;
        if ({a_if.busy, a_if.done, a_if.shift_en} !== 3'b100) begin
            n_err++; $display("FAIL single_gap_state: busy/done/en %b, expected 100", {a_if.busy, a_if.done, a_if.shift_en});
        end
        @(negedge clock); #1;
        n_cmp++;
        if (a_if.busy !== 1'b0) begin n_err++; $display("FAIL single_idle_after_gap: busy %b, expected 0", a_if.busy); end
    endtask

    task automatic test_tie();
        logic [W-1:0] bits, regv; int fe, nen, dc; logic did;
        do_reset();
        @(negedge clock);
        a_if.req0_valid = 1'b1; a_if.req0_data = 4'hA;
        a_if.req1_valid = 1'b1; a_if.req1_data = 4'h5;
        #1;
        n_cmp++;
        if ({a_if.req0_ready, a_if.req1_ready} !== 2'b10) begin
            n_err++; $display("FAIL tie_first_ready: got %b, expected 10", {a_if.req0_ready, a_if.req1_ready});
        end
        @(posedge clock); #1;
        a_if.req0_valid = 1'b0;
        observe(bits, fe, nen, dc, did, regv);
        n_cmp++;
        if ({dc[3:0], did, regv} !== {4'd5, 1'b0, 4'hA}) begin
            n_err++; $display("FAIL tie_first_done: cycle %0d id %b reg %h, expected 5 0 a", dc, did, regv);
        end
        @(negedge clock); #1;
        n_cmp++;
        if ({a_if.busy, a_if.req1_ready} !== 2'b10) begin
            n_err++; $display("FAIL tie_gap_cycle: busy/ready1 %b, expected 10", {a_if.busy, a_if.req1_ready});
        end
        @(negedge clock); #1;
        n_cmp++;
        if ({a_if.req0_ready, a_if.req1_ready} !== 2'b01) begin
            n_err++; $display("FAIL tie_second_ready: got %b, expected 01", {a_if.req0_ready, a_if.req1_ready});
        end
        @(posedge clock); #1;
        a_if.req1_valid = 1'b0;
        observe(bits, fe, nen, dc, did, regv);
        n_cmp++;
        if ({dc[3:0], did, regv, bits} !== {4'd5, 1'b1, 4'h5, 4'h5}) begin
            n_err++; $display("FAIL tie_second_done: cycle %0d id %b reg %h bits %h, expected 5 1 5 5", dc, did, regv, bits);
        end
    endtask

    task automatic test_alternate();
        logic [5:0] grants, dones; int ng, nd, both;
        grants = '0; dones = '0; ng = 0; nd = 0; both = 0;
        do_reset();
        @(negedge clock);
        a_if.req0_valid = 1'b1; a_if.req0_data = 4'hA;
        a_if.req1_valid = 1'b1; a_if.req1_data = 4'h5;
        for (int t = 0; t < 80; t++) begin
            if (t > 0) @(negedge clock);
            #1;
            if (a_if.req0_ready && a_if.req1_ready) both++;
            if ((a_if.req0_ready || a_if.req1_ready) && ng < 6) begin grants[ng] = a_if.req1_ready; ng++; end
            if (a_if.done && nd < 6) begin dones[nd] = a_if.done_id; nd++; end
            if (nd == 6) break;
        end
        a_if.req0_valid = 1'b0; a_if.req1_valid = 1'b0;
        n_cmp++;
        if (nd !== 6) begin n_err++; $display("FAIL alt_timeout: %0d transfers done, expected 6", nd); end
        n_cmp++;
        if (grants !== 6'b101010) begin n_err++; $display("FAIL alt_grants: got %b, expected 101010", grants); end
        n_cmp++;
        if (dones !== 6'b101010) begin n_err++; $display("FAIL alt_done_ids: got %b, expected 101010", dones); end
        n_cmp++;
        if (both !== 0) begin n_err++; $display("FAIL alt_both_ready: %0d cycles, expected 0", both); end
    endtask

    task automatic test_reset_mid_shift();
        logic [W-1:0] bits, regv; int fe, nen, dc, seen_done; logic did;
        logic [6:0] outs;
        do_reset();
        @(negedge clock);
        a_if.req1_valid = 1'b1; a_if.req1_data = 4'h6;
        @(posedge clock); #1;
        a_if.req1_valid = 1'b0;
        @(negedge clock);
        @(negedge clock); #1;
        n_cmp++;
        if ({a_if.shift_en, a_if.grant_id} !== 2'b11) begin
            n_err++; $display("FAIL rst_pre_state: en/grant %b, expected 11", {a_if.shift_en, a_if.grant_id});
        end
        @(negedge clock);
        reset = 1'b1;
        #1;
        outs = {a_if.shift_en, a_if.shift_bit, a_if.busy, a_if.grant_id, a_if.done, a_if.done_id, a_if.req0_ready};
        n_cmp++;
        if (outs !== 7'h00) begin n_err++; $display("FAIL rst_async_outputs: got %b, expected 0000000", outs); end
        seen_done = 0;
        for (int t = 0; t < 4; t++) begin
            @(negedge clock); #1;
            if (a_if.done || a_if.busy) seen_done++;
        end
        reset = 1'b0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clock); #1;
            if (a_if.done || a_if.busy) seen_done++;
        end
        n_cmp++;
        if (seen_done !== 0) begin n_err++; $display("FAIL rst_no_done: %0d active cycles, expected 0", seen_done); end
        a_if.req0_valid = 1'b1; a_if.req0_data = 4'h9;
        a_if.req1_valid = 1'b1; a_if.req1_data = 4'h6;
        #1;
        n_cmp++;
        if ({a_if.req0_ready, a_if.req1_ready} !== 2'b10) begin
            n_err++; $display("FAIL rst_regrant: got %b, expected 10", {a_if.req0_ready, a_if.req1_ready});
        end
        @(posedge clock); #1;
        a_if.req0_valid = 1'b0; a_if.req1_valid = 1'b0;
        observe(bits, fe, nen, dc, did, regv);
        n_cmp++;
        if ({dc[3:0], did, regv} !== {4'd5, 1'b0, 4'h9}) begin
            n_err++; $display("FAIL rst_next_done: cycle %0d id %b reg %h, expected 5 0 9", dc, did, regv);
        end
    endtask

    task automatic test_data_change();
        logic [W-1:0] bits, regv; int fe, nen, dc; logic did;
        do_reset();
        @(negedge clock);
        a_if.req1_valid = 1'b1; a_if.req1_data = 4'h3;
        @(posedge clock); #1;
        a_if.req1_data = 4'hC;
        a_if.req1_valid = 1'b0;
        observe(bits, fe, nen, dc, did, regv);
        n_cmp++;
        if (bits !== 4'h3) begin n_err++; $display("FAIL hold_bits: got %b, expected 0011", bits); end
        n_cmp++;
        if ({did, regv} !== {1'b1, 4'h3}) begin
            n_err++; $display("FAIL hold_done: id %b reg %h, expected 1 3", did, regv);
        end
    endtask

    task automatic test_back_to_back();
        int done_t[3]; int nd, en_cnt, low_cnt, run, max_run;
        logic [W-1:0] reg_first;
        nd = 0; en_cnt = 0; low_cnt = 0; run = 0; max_run = 0; reg_first = '0;
        do_reset();
        @(negedge clock);
        b_if.req1_valid = 1'b1; b_if.req1_data = 4'h9;
        for (int t = 0; t < 24; t++) begin
            if (t > 0) @(negedge clock);
            #1;
            if (t < 18) begin
                if (b_if.shift_en) en_cnt++;
                if (!b_if.busy) begin low_cnt++; run++; if (run > max_run) max_run = run; end
                else run = 0;
            end
            if (b_if.done && nd < 3) begin
                if (nd == 0) reg_first = q_b;
                done_t[nd] = t; nd++;
            end
        end
        b_if.req1_valid = 1'b0;
        n_cmp++;
        if (nd !== 3) begin n_err++; $display("FAIL b2b_done_count: got %0d, expected 3", nd); end
        else begin
            n_cmp++;
            if (done_t[0] !== 5 || done_t[1] - done_t[0] !== 6 || done_t[2] - done_t[1] !== 6) begin
                n_err++; $display("FAIL b2b_done_spacing: at %0d %0d %0d, expected 5 11 17", done_t[0], done_t[1], done_t[2]);
            end
        end
        n_cmp++;
        if (en_cnt !== 12) begin n_err++; $display("FAIL b2b_shift_duty: %0d of 18, expected 12", en_cnt); end
        n_cmp++;
        if (low_cnt !== 3 || max_run !== 1) begin
            n_err++; $display("FAIL b2b_busy_low: %0d cycles, longest %0d, expected 3 and 1", low_cnt, max_run);
        end
        n_cmp++;
        if (reg_first !== 4'h9) begin n_err++; $display("FAIL b2b_register: got %h, expected 9", reg_first); end
    endtask

    initial begin
        reset = 1'b1;
        a_if.req0_valid = 1'b0; a_if.req0_data = '0;
        a_if.req1_valid = 1'b0; a_if.req1_data = '0;
        b_if.req0_valid = 1'b0; b_if.req0_data = '0;
        b_if.req1_valid = 1'b0; b_if.req1_data = '0;
        test_reset();
        test_single();
        test_tie();
        test_alternate();
        test_reset_mid_shift();
        test_data_change();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/shift_port_arbiter.md
Name: shift_port_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one serial-in shift register (serial input, 1 bit per clock) between two parallel-word requesters.
- Accepts a WIDTH-bit word from the granted requester, then serialises it LSB-first over WIDTH clocks using shift_en/shift_bit.
- Pulses done when the register holds the word: data[0] in the oldest stage (Q0), data[WIDTH-1] in the newest stage (Q3 for WIDTH=4).
- Sits between requester logic and the shift register; the only agent that drives the register's serial input and shift qualification.

Parameters:
- WIDTH, 4, word length in bits and number of shift clocks per transfer (≥2).
- GAP, 1, idle cycles inserted after done before the next grant (0..15).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high.
- req0_valid  input  1  requester 0 has a word.
- req0_data  input  WIDTH  requester 0 word.
- req0_ready  output  1  requester 0 word accepted this cycle when valid&&ready.
- req1_valid  input  1  requester 1 has a word.
- req1_data  input  WIDTH  requester 1 word.
- req1_ready  output  1  requester 1 word accepted this cycle when valid&&ready.
- shift_en  output  1  shift register must shift this cycle (clock-enable / gated source).
- shift_bit  output  1  serial data into the register; valid while shift_en=1.
- busy  output  1  transfer in progress (any state other than IDLE).
- grant_id  output  1  requester owning the current transfer.
- done  output  1  one-cycle pulse, word fully loaded.
- done_id  output  1  owner of the completed word; valid with done.

Behaviour:
- Reset (async) values: state=IDLE, shift_en=0, shift_bit=0, busy=0, grant_id=0, done=0, done_id=0, bit counter=0, gap counter=0, last_grant=1 (requester 0 wins the first tie). The shift register shares this reset; a transfer cut by reset is discarded and produces no done.
- States: IDLE → SHIFT → DONE → GAP (skipped if GAP=0) → IDLE.
- Arbitration in IDLE only, combinational from the valids and last_grant:
  - Only one valid: that requester is selected.
  - Both valid: the requester ≠ last_grant is selected.
  - reqN_ready = (state==IDLE) && selected==N. At most one ready high at any time; ready is 0 in every other state.
- Accept: on a clock edge with valid&&ready, register the data word, grant_id := N, last_grant := N, bit counter := 0, state := SHIFT.
- SHIFT lasts exactly WIDTH cycles:
  - shift_en=1 and shift_bit=word[counter], counter 0..WIDTH-1.
  - shift_en and shift_bit are registered outputs; first shift_en is the cycle after acceptance.
  - After the cycle with counter=WIDTH-1, state := DONE.
- DONE, 1 cycle: done=1, done_id=grant_id, shift_en=0. Then state := GAP with gap counter=GAP, or IDLE if GAP=0.
- GAP: counts down GAP cycles, then IDLE.
- Latency: acceptance edge to done pulse = WIDTH+1 cycles. Back-to-back (GAP=0) throughput is one word per WIDTH+2 cycles.
- shift_en=0 in every state except SHIFT.
- Changes of reqN_data or reqN_valid after acceptance have no effect on the transfer in flight.
- A requester dropping valid before acceptance is legal and loses nothing.
- Counter width: $clog2(WIDTH); comparisons against WIDTH-1 only, no wrap ambiguity.
- busy=1 for SHIFT, DONE and GAP.

Test Plan:
- Reset, then req0 valid with data=4'b1011 alone → req0_ready=1 that cycle; shift_bit sequence 1,1,0,1 over 4 cycles with shift_en=1; done pulse on cycle 5 after acceptance with done_id=0; register reads Q3..Q0=1,0,1,1.
- Both valid from reset, data0=4'hA, data1=4'h5, GAP=1 → req0 served first (done_id=0, register=A), one idle cycle, then req1 (done_id=1, register=5).
- Both held valid continuously for 6 transfers → grant alternates 0,1,0,1,0,1; req0_ready and req1_ready never high together.
- Assert reset during SHIFT after 2 bits → all outputs return to reset values immediately; no done pulse; the next transfer grants req0 again.
- Change req1_data from 4'h3 to 4'hC in the cycle after acceptance → serialised bits remain 1,1,0,0 (4'h3 LSB-first).
- GAP=0, req1 only and always valid → done every 6 cycles; shift_en duty 4/6; busy low exactly one cycle between transfers.
